// File: rtl/alu_framer_pipe.sv
// ALU result framer: buffers result words in a FIFO and emits length-N frames with SOF/EOF.
// Optional ALU_FRAMER_PARITY_EN adds frame_par, the XOR of frame_data, registered with it.
module alu_framer_pipe #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int LEN_W     = 5,
  parameter int BP_MARGIN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              frame_len_val,
  output logic              frame_len_rdy,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_ready,
  output logic              frame,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_sof,
  output logic              frame_eof,
  input  logic              frame_rdy,
  output logic              frame_bp,
  output logic              ovf_err,
`ifdef ALU_FRAMER_PARITY_EN
  output logic              frame_par,
`endif
  input  logic              clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if ((2**LEN_W) - 1 > DEPTH) begin : g_len_chk
      $error("alu_framer_pipe: 2**LEN_W-1 exceeds DEPTH");
    end
    if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_depth_chk
      $error("alu_framer_pipe: DEPTH must be a power of 2 and at least 4");
    end
    if (BP_MARGIN >= DEPTH) begin : g_bp_chk
      $error("alu_framer_pipe: BP_MARGIN must be below DEPTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, PENDING, FRAMING} state_t;

  state_t            state, nstate;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     count, count_next;
  logic [LEN_W-1:0]  remaining;
  logic              first;
  logic              full, push, pop, cmd_go;

  assign frame_len_rdy = (state == IDLE);
  assign cmd_go        = (state == IDLE) && frame_len_val && (frame_len != '0);

  always_comb begin
    full       = (count == CW'(DEPTH));
    push       = alu_ready && !full;
    pop        = (state == FRAMING) && (remaining != '0) && (!frame || frame_rdy);
    count_next = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (cmd_go) nstate = PENDING;
      // Wait until the whole frame is buffered so beats never bubble mid-frame.
      PENDING: if (count >= CW'(remaining)) nstate = FRAMING;
      FRAMING: if (frame && frame_rdy && remaining == '0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= alu_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ovf_err    <= 1'b0;
      frame_bp   <= 1'b0;
      remaining  <= '0;
      first      <= 1'b0;
      frame      <= 1'b0;
      frame_data <= '0;
      frame_sof  <= 1'b0;
      frame_eof  <= 1'b0;
`ifdef ALU_FRAMER_PARITY_EN
      frame_par  <= 1'b0;
`endif
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count_next;
      frame_bp <= (CW'(DEPTH) - count_next) <= CW'(BP_MARGIN);
      // A fresh overflow beats a simultaneous clear.
      if (alu_ready && full) ovf_err <= 1'b1;
      else if (clr_err)      ovf_err <= 1'b0;
      if (cmd_go) begin
        remaining <= frame_len;
        first     <= 1'b1;
      end
      if (pop) begin
        frame      <= 1'b1;
        frame_data <= mem[rptr];
        frame_sof  <= first;
        frame_eof  <= (remaining == LEN_W'(1));
        remaining  <= remaining - 1'b1;
        first      <= 1'b0;
`ifdef ALU_FRAMER_PARITY_EN
        frame_par  <= ^mem[rptr];
`endif
      end else if (frame && frame_rdy) begin
        frame     <= 1'b0;
        frame_sof <= 1'b0;
        frame_eof <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_framer_pipe.sv
// Bench for alu_framer_pipe: directed vector table, corner sequences and random traffic,
// all checked each cycle against a queue-based reference model.
module tb_alu_framer_pipe;
  localparam int DATA_W = 32, DEPTH = 32, LEN_W = 5, BP_MARGIN = 3;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic              frame_len_val = 1'b0, frame_len_rdy;
  logic [DATA_W-1:0] alu_data = '0;
  logic              alu_ready = 1'b0;
  logic              frame, frame_sof, frame_eof, frame_bp, ovf_err;
  logic [DATA_W-1:0] frame_data;
  logic              frame_rdy = 1'b1, clr_err = 1'b0;
`ifdef ALU_FRAMER_PARITY_EN
  logic              frame_par;
`endif

  always #5 clk = ~clk;

  alu_framer_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .BP_MARGIN(BP_MARGIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_len(frame_len), .frame_len_val(frame_len_val), .frame_len_rdy(frame_len_rdy),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .frame(frame), .frame_data(frame_data), .frame_sof(frame_sof), .frame_eof(frame_eof),
    .frame_rdy(frame_rdy), .frame_bp(frame_bp), .ovf_err(ovf_err),
`ifdef ALU_FRAMER_PARITY_EN
    .frame_par(frame_par),
`endif
    .clr_err(clr_err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered words as a queue, frame progress as counts.
  logic [DATA_W-1:0] m_q[$];
  int                m_phase;   // 0 waiting for command, 1 collecting words, 2 sending
  int                m_left, m_sent;
  bit                m_vld, m_sof, m_eof, m_ovf, m_bp;
  logic [DATA_W-1:0] m_data;

  function automatic void m_reset();
    m_q.delete();
    m_phase = 0; m_left = 0; m_sent = 0;
    m_vld = 0; m_sof = 0; m_eof = 0; m_ovf = 0; m_bp = 0; m_data = '0;
  endfunction

  function automatic void m_step();
    bit was_full = (m_q.size() == DEPTH);
    bit take     = (m_phase == 2) && (m_left > 0) && (!m_vld || frame_rdy);
    case (m_phase)
      0: if (frame_len_val && frame_len != 0) begin
           m_phase = 1; m_left = int'(frame_len); m_sent = 0;
         end
      1: if (m_q.size() >= m_left) m_phase = 2;
      default:
        if (take) begin
          m_data = m_q.pop_front();
          m_vld  = 1; m_sof = (m_sent == 0); m_eof = (m_left == 1);
          m_left--; m_sent++;
        end else if (m_vld && frame_rdy) begin
          m_vld = 0; m_sof = 0; m_eof = 0; m_phase = 0;
        end
    endcase
    if (alu_ready && !was_full) m_q.push_back(alu_data);
    if (alu_ready && was_full) m_ovf = 1;
    else if (clr_err)          m_ovf = 0;
    m_bp = (DEPTH - m_q.size()) <= BP_MARGIN;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  int                beats = 0;
  logic [DATA_W-1:0] last = '0;

  // Inputs change 2 time units after posedge, so at negedge everything is stable.
  always @(negedge clk) begin
    chk("frame", frame, m_vld);
    chk("len_rdy", frame_len_rdy, m_phase == 0);
    chk("bp", frame_bp, m_bp);
    chk("ovf", ovf_err, m_ovf);
    if (m_vld) begin
      chk("data", frame_data, m_data);
      chk("sof", frame_sof, m_sof);
      chk("eof", frame_eof, m_eof);
`ifdef ALU_FRAMER_PARITY_EN
      chk("par", frame_par, ^m_data);
`endif
    end
    if (rst_n && frame && frame_rdy) begin
      beats++;
      last = frame_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    alu_ready = 1'b1; alu_data = d;
    tick();
    alu_ready = 1'b0;
  endtask

  task automatic cmd(input int len);
    frame_len = LEN_W'(len); frame_len_val = 1'b1;
    tick();
    frame_len_val = 1'b0;
  endtask

  task automatic wait_beats(input int n, input logic [3:0] pat);
    for (int c = 0; c < 400 && beats < n; c++) begin
      frame_rdy = pat[c % 4];
      tick();
    end
    frame_rdy = 1'b1;
    chk("beat_count", beats, n);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50 && !frame_len_rdy; c++) tick();
    chk("back_to_idle", frame_len_rdy, 1);
  endtask

  typedef struct {
    int                nwr;
    int                len;
    logic [DATA_W-1:0] base;
    logic [3:0]        pat;
    int                exp_beats;
    logic [DATA_W-1:0] exp_last;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{4,  4,  32'hA0,   4'hF,    4,  32'hA3};
    vt[1] = '{5,  5,  32'hB0,   4'b1001, 5,  32'hB4};
    vt[2] = '{1,  1,  32'hC0,   4'hF,    1,  32'hC0};
    vt[3] = '{0,  0,  32'h0,    4'hF,    0,  32'h0};
    vt[4] = '{31, 31, 32'h1000, 4'hF,    31, 32'h101E};
    vt[5] = '{31, 31, 32'h2000, 4'hF,    31, 32'h201E};
    vt[6] = '{31, 31, 32'h3000, 4'hB,    31, 32'h301E};

    #3;
    chk("rst_frame", frame, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_sof_eof", {frame_sof, frame_eof}, 0);
    chk("rst_bp_ovf", {frame_bp, ovf_err}, 0);
    chk("rst_len_rdy", frame_len_rdy, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      beats = 0;
      for (int w = 0; w < vt[i].nwr; w++) wr(vt[i].base + w);
      cmd(vt[i].len);
      if (vt[i].exp_beats > 0) wait_beats(vt[i].exp_beats, vt[i].pat);
      else repeat (5) tick();
      chk("vec_beats", beats, vt[i].exp_beats);
      if (vt[i].exp_beats > 0) chk("vec_last", last, vt[i].exp_last);
      wait_idle();
    end

    // Command before data: frame waits until all 3 words are buffered.
    beats = 0;
    cmd(3);
    for (int w = 0; w < 3; w++) begin
      chk("pending_no_beat", frame, 0);
      wr(32'hE0 + w);
      tick();
    end
    wait_beats(3, 4'hF);
    chk("pending_last", last, 32'hE2);
    wait_idle();

    // Fill, back-pressure threshold, overflow, clear.
    for (int w = 0; w < 28; w++) wr(32'h5000 + w);
    chk("bp_at_28", frame_bp, 0);
    wr(32'h5000 + 28);
    chk("bp_at_29", frame_bp, 1);
    for (int w = 29; w < 32; w++) wr(32'h5000 + w);
    chk("ovf_at_32", ovf_err, 0);
    wr(32'h5000 + 32);
    chk("ovf_at_33", ovf_err, 1);
    alu_ready = 1'b1; alu_data = 32'hDEAD; clr_err = 1'b1;
    tick();
    alu_ready = 1'b0;
    chk("ovf_set_wins", ovf_err, 1);
    tick();
    clr_err = 1'b0;
    chk("ovf_cleared", ovf_err, 0);
    beats = 0;
    cmd(31);
    wait_beats(31, 4'hF);
    chk("drain_last", last, 32'h501E);
    wait_idle();
    beats = 0;
    cmd(1);
    wait_beats(1, 4'hF);
    chk("drain_final", last, 32'h501F);
    wait_idle();

    // Reset in the middle of a frame, then a clean frame with fresh data.
    for (int w = 0; w < 4; w++) wr(32'h6000 + w);
    beats = 0;
    cmd(4);
    for (int c = 0; c < 50 && beats < 2; c++) tick();
    chk("mid_frame_reached", beats >= 2, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_frame", frame, 0);
    chk("arst_data", frame_data, 0);
    chk("arst_sof_eof", {frame_sof, frame_eof}, 0);
    chk("arst_bp_ovf", {frame_bp, ovf_err}, 0);
    chk("arst_len_rdy", frame_len_rdy, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    wr(32'h7000); wr(32'h7001);
    beats = 0;
    cmd(2);
    wait_beats(2, 4'hF);
    chk("post_rst_last", last, 32'h7001);
    wait_idle();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      alu_ready     = ($urandom % 3) != 0;
      alu_data      = $urandom;
      frame_rdy     = ($urandom % 4) != 0;
      frame_len_val = ($urandom % 6) == 0;
      frame_len     = LEN_W'($urandom % 32);
      clr_err       = ($urandom % 20) == 0;
      tick();
    end
    alu_ready = 1'b0; frame_len_val = 1'b0; clr_err = 1'b0; frame_rdy = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
